shot_clock_ctrl: RTL and testbench
==================================

Name: shot_clock_ctrl

Overview:
Control front-end that sits directly upstream of the shot-clock countdown counter on the DE10 board. It conditions the raw active-low KEY pushbuttons (pause/start and load) and the mode switch. From these it generates the counter's one-cycle load request with the 24/30 s preset value, a run-gated 1 Hz tick strobe in the system clock domain, and run/paused/expired status.

Parameters:
CLK_HZ, 50000000, system clock cycles per 1 Hz tick.
DEBOUNCE_CYCLES, 500000, cycles a synchronized key must hold a new level before it is accepted (10 ms at 50 MHz).
SHORT_VAL, 24, preset seconds when sw_mode=0.
LONG_VAL, 30, preset seconds when sw_mode=1.

Ports:
clk  in  1  system clock, 50 MHz.
reset  in  1  asynchronous, active-low reset.
key_pause  in  1  raw pushbutton, active-low, asynchronous; a press toggles start/pause.
key_load  in  1  raw pushbutton, active-low, asynchronous; a press reloads the preset.
sw_mode  in  1  raw slide switch; 0 selects SHORT_VAL, 1 selects LONG_VAL.
count_zero  in  1  high while the downstream counter value equals 0.
load_pulse  out  1  one-cycle request for the counter to load load_value.
load_value  out  5  preset seconds value.
tick_1hz  out  1  one-cycle strobe; the counter decrements on it.
run  out  1  high in RUN.
paused  out  1  high in PAUSED.
expired  out  1  high in EXPIRED.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low. All flops clear on reset low.
- Reset values: state=IDLE; load_pulse, tick_1hz, run, paused and expired all 0; prescaler=0; debounce counters=0; synchronizer and stable key levels=1 (released); sw sync=0, so load_value=SHORT_VAL.
- Input synchronization: key_pause, key_load and sw_mode each pass through a 2-FF synchronizer.
- Debounce, per key:
  - If sync == stable, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable takes the sync value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Press events: a press event is a one-cycle internal pulse on a stable 1->0 transition. Release (0->1) generates no event. A held key generates exactly one event.
- load_value: SHORT_VAL or LONG_VAL, selected by synced sw_mode and updated continuously. It is sampled by the counter only when load_pulse is high.
- FSM transitions (registered; a transition is evaluated the cycle after the event):
  - IDLE:
    - load event -> load_pulse=1 for 1 cycle, prescaler cleared, stay in IDLE.
    - pause event -> RUN.
  - RUN:
    - load event -> load_pulse, prescaler cleared, -> IDLE.
    - pause event -> PAUSED.
    - count_zero=1 -> EXPIRED.
  - PAUSED:
    - pause event -> RUN.
    - load event -> load_pulse, prescaler cleared, -> IDLE.
  - EXPIRED:
    - pause event is ignored.
    - load event -> load_pulse, prescaler cleared, -> IDLE.
- Entering RUN with count_zero already 1 goes to EXPIRED on the next cycle, and no tick is issued.
- Simultaneous events: load and pause events in the same cycle -> the load takes priority and the pause event is discarded.
- Priority within RUN: load, then count_zero, then pause.
- Prescaler:
  - It is ceil(log2(CLK_HZ)) bits wide and counts only in RUN.
  - At CLK_HZ-1 it wraps to 0 and tick_1hz=1 for exactly that cycle.
  - It holds its value in PAUSED, so the partial second is preserved across a pause/resume.
  - It is cleared on any load_pulse and in IDLE and EXPIRED.
  - The first tick comes CLK_HZ cycles after entering RUN from IDLE.
- Status outputs: run, paused and expired are registered decodes of state.
- Reset mid-operation: all outputs drop combinationally-asynchronously with reset. No load_pulse is issued on reset release; the downstream counter shares reset.

Test Plan:
(Bench parameters: CLK_HZ=10, DEBOUNCE_CYCLES=4, SHORT_VAL=24, LONG_VAL=30.)
1. Reset low, then high; hold keys high -> run/paused/expired/tick_1hz/load_pulse all 0, load_value=24; no pulses for 100 cycles.
2. sw_mode=1 held; key_load low for 3 cycles, then low for 10 cycles -> first (glitch) produces no load_pulse; second gives exactly one load_pulse with load_value=30, state remains IDLE.
3. key_pause press (held 10 cycles) -> run=1; tick_1hz pulses once every 10 cycles. Count 5 ticks, then key_pause press -> paused=1 and ticks stop. Press again after a prescaler of 6 -> next tick after 4 cycles.
4. In RUN, drive count_zero=1 -> expired=1, run=0 next cycle, no further ticks. key_pause press ignored. key_load press -> one load_pulse, state IDLE.
5. key_load and key_pause pressed with identical timing in RUN -> one load_pulse, state IDLE (not PAUSED), prescaler=0.
6. Assert reset low mid-RUN between ticks -> all outputs 0 immediately. After release, a key_pause press yields a first tick exactly 10 cycles after run rises.

Source files
------------

// File: rtl/shot_clock_ctrl.sv
// Shot-clock control front-end: synchronizes and debounces the KEY/switch inputs,
// then runs the IDLE/RUN/PAUSED/EXPIRED FSM that issues load requests and 1 Hz ticks.
module shot_clock_ctrl #(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SHORT_VAL       = 24,
  parameter int LONG_VAL        = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_pause,
  input  logic       key_load,
  input  logic       sw_mode,
  input  logic       count_zero,
  output logic       load_pulse,
  output logic [4:0] load_value,
  output logic       tick_1hz,
  output logic       run,
  output logic       paused,
  output logic       expired
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  // Index 0 is the pause key, index 1 the load key.
  logic [1:0]    w_key_raw;
  logic [1:0]    r_key_s1;
  logic [1:0]    r_key_s2;
  logic [1:0]    r_key_stable;
  logic [1:0]    r_key_ev;
  logic [DW-1:0] r_db_cnt [2];
  logic          r_sw_s1;
  logic          r_sw_s2;
  logic [4:0]    r_load_value;
  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_load_pulse;
  logic          r_tick;
  logic          r_run;
  logic          r_paused;
  logic          r_expired;
  logic          w_pause_ev;
  logic          w_load_ev;

  assign w_key_raw  = {key_load, key_pause};
  assign w_pause_ev = r_key_ev[0];
  assign w_load_ev  = r_key_ev[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_s1 <= 2'b11;
      r_key_s2 <= 2'b11;
      r_sw_s1  <= 1'b0;
      r_sw_s2  <= 1'b0;
    end else begin
      r_key_s1 <= w_key_raw;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= sw_mode;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // A key level is accepted only after it differs from the stable level for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_stable <= 2'b11;
      r_key_ev     <= 2'b00;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= {DW{1'b0}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_key_ev[i] <= 1'b0;
        if (r_key_s2[i] == r_key_stable[i]) begin
          r_db_cnt[i] <= {DW{1'b0}};
        end else if (r_db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_key_stable[i] <= r_key_s2[i];
          r_db_cnt[i]     <= {DW{1'b0}};
          r_key_ev[i]     <= ~r_key_s2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + {{(DW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_load_value <= 5'(SHORT_VAL);
    else        r_load_value <= r_sw_s2 ? 5'(LONG_VAL) : 5'(SHORT_VAL);
  end

  // Load wins over everything in every state; within RUN count_zero beats pause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_presc      <= {PW{1'b0}};
      r_load_pulse <= 1'b0;
      r_tick       <= 1'b0;
      r_run        <= 1'b0;
      r_paused     <= 1'b0;
      r_expired    <= 1'b0;
    end else begin
      r_load_pulse <= 1'b0;
      r_tick       <= 1'b0;
      if (w_load_ev) begin
        r_load_pulse <= 1'b1;
        r_presc      <= {PW{1'b0}};
        r_state      <= S_IDLE;
        r_run        <= 1'b0;
        r_paused     <= 1'b0;
        r_expired    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_presc <= {PW{1'b0}};
            if (w_pause_ev) begin
              r_state <= S_RUN;
              r_run   <= 1'b1;
            end
          end
          S_RUN: begin
            if (count_zero) begin
              r_state   <= S_EXPIRED;
              r_presc   <= {PW{1'b0}};
              r_run     <= 1'b0;
              r_expired <= 1'b1;
            end else if (w_pause_ev) begin
              r_state  <= S_PAUSED;
              r_run    <= 1'b0;
              r_paused <= 1'b1;
            end else if (r_presc == PW'(CLK_HZ - 1)) begin
              r_presc <= {PW{1'b0}};
              r_tick  <= 1'b1;
            end else begin
              r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
            end
          end
          S_PAUSED: begin
            if (w_pause_ev) begin
              r_state  <= S_RUN;
              r_paused <= 1'b0;
              r_run    <= 1'b1;
            end
          end
          S_EXPIRED: begin
            r_presc <= {PW{1'b0}};
          end
          default: begin
            r_state   <= S_IDLE;
            r_presc   <= {PW{1'b0}};
            r_run     <= 1'b0;
            r_paused  <= 1'b0;
            r_expired <= 1'b0;
          end
        endcase
      end
    end
  end

  assign load_pulse = r_load_pulse;
  assign load_value = r_load_value;
  assign tick_1hz   = r_tick;
  assign run        = r_run;
  assign paused     = r_paused;
  assign expired    = r_expired;

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Self-checking bench for shot_clock_ctrl: directed scenarios plus random key/switch
// activity, every cycle compared against a behavioural reference model.
module tb_shot_clock_ctrl;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam int SHORT  = 24;
  localparam int LONG   = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_pause;
  logic       key_load;
  logic       sw_mode;
  logic       count_zero;
  logic       load_pulse;
  logic [4:0] load_value;
  logic       tick_1hz;
  logic       run;
  logic       paused;
  logic       expired;

  shot_clock_ctrl #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB), .SHORT_VAL(SHORT), .LONG_VAL(LONG)
  ) dut (
    .clk(clk), .reset(reset), .key_pause(key_pause), .key_load(key_load),
    .sw_mode(sw_mode), .count_zero(count_zero), .load_pulse(load_pulse),
    .load_value(load_value), .tick_1hz(tick_1hz), .run(run), .paused(paused),
    .expired(expired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_lp  = 0;
  int n_tick = 0;
  int last_lv = 0;

  // Reference model: inputs reach the debouncer two clocks late; a key level is
  // accepted once it has differed for DEB consecutive cycles; a press (accepted 1->0)
  // acts on the FSM one cycle later.
  bit m_q_p[$];
  bit m_q_l[$];
  bit m_q_s[$];
  int m_stable [2];
  int m_streak [2];
  bit m_ev [2];
  int m_state;   // 0 idle, 1 run, 2 paused, 3 expired
  int m_presc;
  bit m_lp;
  bit m_tick;
  int m_lv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q_p = '{1'b1, 1'b1};
    m_q_l = '{1'b1, 1'b1};
    m_q_s = '{1'b0, 1'b0};
    for (int k = 0; k < 2; k++) begin
      m_stable[k] = 1;
      m_streak[k] = 0;
      m_ev[k] = 1'b0;
    end
    m_state = 0;
    m_presc = 0;
    m_lp = 1'b0;
    m_tick = 1'b0;
    m_lv = SHORT;
  endtask

  task automatic model_edge();
    int syn [2];
    int sw_syn;
    bit ld;
    bit pa;
    syn[0] = int'(m_q_p.pop_front()); m_q_p.push_back(key_pause);
    syn[1] = int'(m_q_l.pop_front()); m_q_l.push_back(key_load);
    sw_syn = int'(m_q_s.pop_front()); m_q_s.push_back(sw_mode);
    pa = m_ev[0];
    ld = m_ev[1];
    m_lp = 1'b0;
    m_tick = 1'b0;
    if (ld) begin
      m_lp = 1'b1; m_presc = 0; m_state = 0;
    end else if (m_state == 0) begin
      m_presc = 0;
      if (pa) m_state = 1;
    end else if (m_state == 1) begin
      if (count_zero) begin
        m_state = 3; m_presc = 0;
      end else if (pa) begin
        m_state = 2;
      end else begin
        m_presc = m_presc + 1;
        if (m_presc == CLK_HZ) begin
          m_presc = 0; m_tick = 1'b1;
        end
      end
    end else if (m_state == 2) begin
      if (pa) m_state = 1;
    end else begin
      m_presc = 0;
    end
    for (int k = 0; k < 2; k++) begin
      m_ev[k] = 1'b0;
      if (syn[k] == m_stable[k]) begin
        m_streak[k] = 0;
      end else begin
        m_streak[k] = m_streak[k] + 1;
        if (m_streak[k] == DEB) begin
          m_stable[k] = syn[k];
          m_streak[k] = 0;
          m_ev[k] = (syn[k] == 0);
        end
      end
    end
    m_lv = (sw_syn != 0) ? LONG : SHORT;
  endtask

  task automatic step();
    logic [9:0] exp_v;
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    exp_v = {m_lp, 5'(m_lv), m_tick, (m_state == 1), (m_state == 2), (m_state == 3)};
    chk("cycle", 32'({load_pulse, load_value, tick_1hz, run, paused, expired}), 32'(exp_v));
    if (load_pulse) begin
      n_lp++;
      last_lv = int'(load_value);
    end
    if (tick_1hz) n_tick++;
  endtask

  function automatic bit sel(input int which);
    case (which)
      0:       return run;
      1:       return tick_1hz;
      2:       return paused;
      3:       return expired;
      4:       return load_pulse;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, output int waited);
    waited = 0;
    do begin
      step();
      waited++;
    end while (!sel(which) && waited < budget);
    chk("wait_sig", 32'(sel(which)), 32'd1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input int which, input int hold);
    if (which != 1) key_pause = 1'b0;
    if (which != 0) key_load = 1'b0;
    steps(hold);
    key_pause = 1'b1;
    key_load = 1'b1;
  endtask

  initial begin
    int w;
    int held;
    int base_lp;
    int base_tick;
    reset = 1'b0;
    key_pause = 1'b1;
    key_load = 1'b1;
    sw_mode = 1'b0;
    count_zero = 1'b0;
    model_reset();
    steps(3);
    chk("reset_state", 32'({load_pulse, tick_1hz, run, paused, expired}), 32'd0);
    chk("reset_lv", 32'(load_value), 32'(SHORT));

    // 1: quiet idle after reset
    reset = 1'b1;
    base_lp = n_lp; base_tick = n_tick;
    steps(100);
    chk("idle_quiet", 32'(n_lp - base_lp + n_tick - base_tick), 32'd0);

    // 2: glitch rejected, real press loads LONG value
    sw_mode = 1'b1;
    steps(5);
    base_lp = n_lp;
    key_load = 1'b0; steps(3); key_load = 1'b1; steps(10);
    chk("glitch_rejected", 32'(n_lp - base_lp), 32'd0);
    press(1, 10); steps(10);
    chk("load_once", 32'(n_lp - base_lp), 32'd1);
    chk("load_long", 32'(last_lv), 32'(LONG));
    chk("load_stays_idle", 32'({run, paused, expired}), 32'd0);

    // 3: run, tick period, pause holds prescaler, resume finishes the second
    key_pause = 1'b0;
    wait_sig(0, 40, w);
    key_pause = 1'b1;
    wait_sig(1, 40, w);
    chk("first_tick", 32'(w), 32'(CLK_HZ));
    for (int i = 0; i < 4; i++) begin
      wait_sig(1, 40, w);
      chk("tick_period", 32'(w), 32'(CLK_HZ));
    end
    key_pause = 1'b0;
    wait_sig(2, 40, w);
    held = w - 1;
    chk("pause_presc", 32'(held), 32'd6);
    key_pause = 1'b1;
    base_tick = n_tick;
    steps(30);
    chk("paused_no_tick", 32'(n_tick - base_tick), 32'd0);
    key_pause = 1'b0;
    wait_sig(0, 40, w);
    key_pause = 1'b1;
    wait_sig(1, 40, w);
    chk("resume_tick", 32'(w), 32'(CLK_HZ - held));

    // 4: expiry, pause ignored, load returns to idle
    steps(3);
    count_zero = 1'b1;
    wait_sig(3, 10, w);
    chk("expire_latency", 32'(w), 32'd1);
    chk("expire_run_low", 32'(run), 32'd0);
    base_tick = n_tick;
    press(0, 10); steps(15);
    chk("expired_holds", 32'({run, paused, expired}), 32'b001);
    chk("expired_no_tick", 32'(n_tick - base_tick), 32'd0);
    base_lp = n_lp;
    press(1, 10); steps(10);
    chk("expired_reload", 32'(n_lp - base_lp), 32'd1);
    chk("reload_idle", 32'({run, paused, expired}), 32'd0);
    count_zero = 1'b0;

    // 5: simultaneous load and pause in RUN -> load wins
    press(0, 10); steps(10);
    chk("run_again", 32'(run), 32'd1);
    base_lp = n_lp;
    press(2, 10); steps(15);
    chk("both_one_load", 32'(n_lp - base_lp), 32'd1);
    chk("both_idle", 32'({run, paused, expired}), 32'd0);

    // 6: asynchronous reset mid-RUN, then clean restart
    key_pause = 1'b0;
    wait_sig(0, 40, w);
    key_pause = 1'b1;
    steps(4);
    reset = 1'b0;
    #1;
    chk("async_reset_out", 32'({load_pulse, tick_1hz, run, paused, expired}), 32'd0);
    chk("async_reset_lv", 32'(load_value), 32'(SHORT));
    model_reset();
    @(negedge clk);
    steps(3);
    reset = 1'b1;
    base_lp = n_lp;
    steps(8);
    chk("no_load_on_release", 32'(n_lp - base_lp), 32'd0);
    key_pause = 1'b0;
    wait_sig(0, 40, w);
    key_pause = 1'b1;
    wait_sig(1, 40, w);
    chk("restart_first_tick", 32'(w), 32'(CLK_HZ));

    // Random key, switch and count_zero activity against the model
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 5))
        0: press(0, int'($urandom_range(1, 9)));
        1: press(1, int'($urandom_range(1, 9)));
        2: press(2, int'($urandom_range(1, 9)));
        3: sw_mode = ~sw_mode;
        4: count_zero = ($urandom_range(0, 3) == 0);
        default: steps(int'($urandom_range(5, 25)));
      endcase
      steps(int'($urandom_range(1, 12)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
